// File: rtl/servo_pwm_driver.sv
// H-bridge servo PWM driver: samples the PID effort once per SAMPLE_DIV periods,
// maps it to a clipped duty, and drives one leg with dead time on reversal.
module servo_pwm_driver #(
    parameter int PERIOD     = 1000,
    parameter int DEADTIME   = 8,
    parameter int SAMPLE_DIV = 4,
    parameter int SHIFT      = 4
) (
    input  logic               sclk,
    input  logic               rst,
    input  logic signed [17:0] uk,
    output logic               sample_en,
    output logic               pwm_a,
    output logic               pwm_b,
    output logic [15:0]        duty,
    output logic               sat
);

    localparam int DIVW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int DTW  = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
    localparam logic [15:0]     CNT_LAST = 16'(PERIOD - 1);
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(SAMPLE_DIV - 1);
    localparam logic [DTW-1:0]  DT_LAST  = DTW'((DEADTIME > 0) ? DEADTIME - 1 : 0);
    localparam logic [17:0]     PERIOD18 = 18'(PERIOD);

    typedef enum logic {RUN, DEAD} state_t;

    state_t          state;
    logic [15:0]     cnt;
    logic [DIVW-1:0] div;
    logic [DTW-1:0]  dcnt;
    logic [15:0]     sh_duty;
    logic            sh_dir, sh_sat;
    logic            act_dir;

    logic signed [17:0] s;
    logic [17:0]        mag;
    logic               cap_dir, cap_sat;
    logic [15:0]        cap_duty;
    logic [15:0]        nxt_duty;
    logic               nxt_dir, nxt_sat;
    logic               boundary, enter_dead, drive;

    // 18-bit magnitude holds 131072 for the most negative effort at SHIFT=0.
    always_comb begin
        s        = uk >>> SHIFT;
        cap_dir  = s[17];
        mag      = cap_dir ? 18'(-s) : 18'(s);
        cap_sat  = mag > PERIOD18;
        cap_duty = cap_sat ? 16'(PERIOD) : mag[15:0];
    end

    // A capture landing on the boundary edge goes straight to the active registers.
    always_comb begin
        nxt_duty   = sample_en ? cap_duty : sh_duty;
        nxt_dir    = sample_en ? cap_dir  : sh_dir;
        nxt_sat    = sample_en ? cap_sat  : sh_sat;
        boundary   = (cnt == CNT_LAST);
        enter_dead = (DEADTIME > 0) && (nxt_dir != act_dir) &&
                     (duty != 16'd0) && (nxt_duty != 16'd0);
        drive      = (state == RUN) && (cnt < duty);
    end

    always_ff @(posedge sclk) begin
        if (!rst) begin
            cnt       <= '0;
            div       <= '0;
            dcnt      <= '0;
            state     <= RUN;
            sample_en <= 1'b0;
            sh_duty   <= '0;
            sh_dir    <= 1'b0;
            sh_sat    <= 1'b0;
            duty      <= '0;
            act_dir   <= 1'b0;
            sat       <= 1'b0;
            pwm_a     <= 1'b0;
            pwm_b     <= 1'b0;
        end else begin
            cnt       <= boundary ? 16'd0 : cnt + 16'd1;
            sample_en <= (cnt == 16'd0) && (div == '0);
            pwm_a     <= drive && !act_dir;
            pwm_b     <= drive && act_dir;
            if (sample_en) begin
                sh_duty <= cap_duty;
                sh_dir  <= cap_dir;
                sh_sat  <= cap_sat;
            end
            if (boundary) begin
                div     <= (div == DIV_LAST) ? '0 : div + 1'b1;
                duty    <= nxt_duty;
                act_dir <= nxt_dir;
                sat     <= nxt_sat;
                state   <= enter_dead ? DEAD : RUN;
                dcnt    <= '0;
            end else if (state == DEAD) begin
                if (dcnt == DT_LAST) state <= RUN;
                else                 dcnt  <= dcnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_servo_pwm_driver.sv
// Directed bench for servo_pwm_driver with PERIOD=100, DEADTIME=4, SAMPLE_DIV=2, SHIFT=2.
module tb_servo_pwm_driver;

    logic               sclk;
    logic               rst;
    logic signed [17:0] uk;
    logic               sample_en, pwm_a, pwm_b, sat;
    logic [15:0]        duty;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int na, nb, nboth, fa, fb, nse;

    servo_pwm_driver #(.PERIOD(100), .DEADTIME(4), .SAMPLE_DIV(2), .SHIFT(2)) dut (
        .sclk(sclk), .rst(rst), .uk(uk), .sample_en(sample_en),
        .pwm_a(pwm_a), .pwm_b(pwm_b), .duty(duty), .sat(sat)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    // Cycle index: 0 is the cycle after the last reset edge.
    always @(posedge sclk) cyc <= rst ? cyc + 1 : 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic goto(input int k);
        for (int i = 0; i < 4000 && cyc != k; i++) @(negedge sclk);
        chk("goto_cycle", cyc, k);
    endtask

    // Observe outputs over cycles first..first+len-1; fa/fb are offsets of the first high.
    task automatic win(input int first, input int len, output int ca, output int cb,
                       output int cboth, output int oa, output int ob, output int cse);
        goto(first);
        ca = 0; cb = 0; cboth = 0; oa = -1; ob = -1; cse = 0;
        for (int i = 0; i < len; i++) begin
            if (i > 0) @(negedge sclk);
            if (pwm_a) begin ca++; if (oa < 0) oa = i; end
            if (pwm_b) begin cb++; if (ob < 0) ob = i; end
            if (pwm_a && pwm_b) cboth++;
            if (sample_en) cse++;
        end
    endtask

    initial begin
        rst = 1'b0;
        uk  = 18'sd200;
        repeat (3) @(negedge sclk);
        chk("rst_sample_en", sample_en, 0);
        chk("rst_pwm_a", pwm_a, 0);
        chk("rst_pwm_b", pwm_b, 0);
        chk("rst_duty", duty, 0);
        chk("rst_sat", sat, 0);
        rst = 1'b1;

        goto(0);   chk("se_c0", sample_en, 0);
        goto(1);   chk("se_c1", sample_en, 1);
        goto(2);   chk("se_c2", sample_en, 0);
        win(3, 96, na, nb, nboth, fa, fb, nse);
        chk("idle_a", na, 0); chk("idle_b", nb, 0); chk("idle_se", nse, 0);
        goto(99);  chk("duty_pre_load", duty, 0);
        goto(100); chk("duty_fwd50", duty, 50); chk("sat_fwd50", sat, 0);

        win(101, 100, na, nb, nboth, fa, fb, nse);
        chk("fwd50_a", na, 50); chk("fwd50_first_a", fa, 0);
        chk("fwd50_b", nb, 0);  chk("fwd50_se", nse, 0);
        uk = -18'sd400;
        win(201, 100, na, nb, nboth, fa, fb, nse);
        chk("fwd50_p2_a", na, 50); chk("se_c201", nse, 1);
        chk("duty_rev100", duty, 100); chk("sat_rev100", sat, 0);

        win(301, 100, na, nb, nboth, fa, fb, nse);
        chk("rev_dead_b", nb, 96); chk("rev_dead_first_b", fb, 4);
        chk("rev_dead_a", na, 0);  chk("rev_dead_both", nboth, 0);
        uk = 18'sd1000;
        win(401, 100, na, nb, nboth, fa, fb, nse);
        chk("rev_full_b", nb, 100); chk("rev_full_a", na, 0); chk("se_c401", nse, 1);
        chk("duty_sat_fwd", duty, 100); chk("sat_fwd", sat, 1);

        win(501, 100, na, nb, nboth, fa, fb, nse);
        chk("satfwd_dead_a", na, 96); chk("satfwd_first_a", fa, 4); chk("satfwd_b", nb, 0);
        uk = -18'sd131072;
        win(601, 100, na, nb, nboth, fa, fb, nse);
        chk("satfwd_full_a", na, 100); chk("satfwd_full_both", nboth, 0);
        chk("duty_minneg", duty, 100); chk("sat_minneg", sat, 1);

        win(701, 100, na, nb, nboth, fa, fb, nse);
        chk("minneg_b", nb, 96); chk("minneg_first_b", fb, 4); chk("minneg_a", na, 0);
        uk = 18'sd0;
        win(801, 100, na, nb, nboth, fa, fb, nse);
        chk("minneg_full_b", nb, 100);
        chk("duty_zero", duty, 0); chk("sat_zero", sat, 0);

        win(901, 100, na, nb, nboth, fa, fb, nse);
        chk("zero_a", na, 0); chk("zero_b", nb, 0);
        uk = 18'sd8;
        win(1001, 100, na, nb, nboth, fa, fb, nse);
        chk("zero_p2_a", na, 0); chk("zero_p2_b", nb, 0);
        chk("duty_two", duty, 2);

        win(1101, 100, na, nb, nboth, fa, fb, nse);
        chk("two_a", na, 2); chk("two_first_a", fa, 0); chk("two_b", nb, 0);
        uk = -18'sd1;
        win(1201, 100, na, nb, nboth, fa, fb, nse);
        chk("two_p2_a", na, 2);
        chk("duty_neg1", duty, 1); chk("sat_neg1", sat, 0);

        win(1301, 100, na, nb, nboth, fa, fb, nse);
        chk("neg1_dead_b", nb, 0); chk("neg1_dead_a", na, 0);
        uk = 18'sd400;
        win(1401, 100, na, nb, nboth, fa, fb, nse);
        chk("neg1_b", nb, 1); chk("neg1_first_b", fb, 0); chk("neg1_a", na, 0);
        chk("duty_fwd100", duty, 100); chk("sat_fwd100", sat, 0);

        goto(1637);
        chk("pre_rst_pwm_a", pwm_a, 1);
        rst = 1'b0;
        uk  = 18'sd0;
        @(negedge sclk);
        chk("midrst_pwm_a", pwm_a, 0); chk("midrst_pwm_b", pwm_b, 0);
        chk("midrst_duty", duty, 0);   chk("midrst_sat", sat, 0);
        chk("midrst_se", sample_en, 0);
        repeat (2) @(negedge sclk);
        rst = 1'b1;
        goto(1); chk("post_rst_se_c1", sample_en, 1);
        win(2, 149, na, nb, nboth, fa, fb, nse);
        chk("post_rst_a", na, 0); chk("post_rst_b", nb, 0); chk("post_rst_se", nse, 0);
        chk("post_rst_duty", duty, 0);
        goto(201); chk("post_rst_se_c201", sample_en, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/servo_pwm_driver.md
SERVO_PWM_DRIVER -- requirements
Module: servo_pwm_driver

Interface
REQ-001 Parameters SHALL be as follows, one per line (name, default, meaning):
- PERIOD, 1000: PWM period in sclk cycles, range 2..65535.
- DEADTIME, 8: both-low cycles inserted on direction reversal, less than PERIOD.
- SAMPLE_DIV, 4: PWM periods per control sample, 1 or more.
- SHIFT, 4: arithmetic right shift applied to uk before duty mapping, range 0..17.

REQ-002 Ports SHALL be as follows, one per line (name, direction, width, meaning):
- sclk  input  1  single clock; all state changes on rising edge.
- rst  input  1  reset; synchronous, active-low.
- uk  input  18  signed two's-complement control effort from the pid block's pid_output.
- sample_en  output  1  one-cycle strobe driving the pid block's enable.
- pwm_a  output  1  H-bridge forward drive.
- pwm_b  output  1  H-bridge reverse drive.
- duty  output  16  active duty magnitude, in cycles.
- sat  output  1  the active duty was clipped to PERIOD.

Function
REQ-003 Period counter cnt SHALL count 0..PERIOD-1 and wrap to 0; the wrap cycle (cnt==PERIOD-1) is a "boundary".
REQ-004 Period divider div SHALL increment at each boundary and wrap from SAMPLE_DIV-1 to 0.
REQ-005 sample_en SHALL be a registered one-cycle pulse, high in the cycle after an edge that samples cnt==0 and div==0, i.e. exactly once every PERIOD*SAMPLE_DIV cycles.
REQ-006 uk SHALL be captured at the clock edge that ends the sample_en-high cycle (pid latency 1); uk is ignored at all other times.
REQ-007 Capture SHALL compute s = uk >>> SHIFT (arithmetic, rounding toward minus infinity), dir = sign of s, and mag = |s|.
- uk = -131072 SHALL yield mag = 131072 >> SHIFT with no overflow.
REQ-008 If mag > PERIOD, the shadow duty SHALL be PERIOD and the shadow sat flag SHALL be 1; otherwise the shadow duty = mag and shadow sat = 0.
REQ-009 Shadow duty, dir and sat SHALL transfer to the active registers only at a boundary. A new value therefore takes effect from the next period start and never mid-period.
REQ-010 Per-period states SHALL be RUN and DEAD.
- At a boundary, enter DEAD if the new dir differs from the old dir and both the old and new active duty are nonzero; otherwise enter RUN.
- DEAD SHALL last DEADTIME cycles and then go to RUN.
REQ-011 pwm_a and pwm_b SHALL be registered outputs.
- In a period, the driven output (pwm_a if dir is positive or zero, pwm_b if negative) SHALL be high for the cycles where the delayed cnt < duty and the state is RUN.
- The other output SHALL be 0.
REQ-012 pwm_a and pwm_b SHALL never be 1 simultaneously, under any input sequence.
REQ-013 Duty boundary cases:
- duty = 0 SHALL drive both outputs low for the whole period.
- duty = PERIOD SHALL drive the selected output high continuously across consecutive periods, with no one-cycle glitch.
REQ-014 duty and sat outputs SHALL reflect the active registers, so they update at boundaries only.
REQ-015 If a sample capture and a boundary fall on the same edge, the active registers SHALL load the value captured on that edge.

Reset
REQ-016 While rst==0 at an edge, the block SHALL set cnt=0, div=0, state=RUN, dir positive, and shadow duty/sat = 0.
REQ-017 Reset SHALL drive all outputs low: sample_en=0, pwm_a=0, pwm_b=0, duty=0, sat=0.
REQ-018 Reset asserted mid-period SHALL force pwm_a and pwm_b low from the next edge and discard any pending shadow value.

Verification
REQ-019 Benches SHALL use PERIOD=100, DEADTIME=4, SAMPLE_DIV=2, SHIFT=2 and cover the following scenarios:
- Reset release -> all outputs 0 during reset; first sample_en 1 cycle after release, then every 200 cycles; outputs stay low until the first loaded boundary.
- uk=+200 at capture -> from the next boundary: duty=50, sat=0, pwm_a high exactly 50 cycles per period, pwm_b=0.
- Forward duty 50, then uk=-400 -> reversal period: pwm_b low 4 cycles, then high 96 cycles; following period: 100 cycles high; pwm_a=0 throughout.
- uk=+1000 -> duty=100, sat=1, pwm_a continuously high; then uk=-131072 -> duty=100, sat=1, pwm_b high after 4 dead cycles.
- uk=0 after reverse drive -> both outputs low all period, no DEAD state; then uk=+8 -> duty=2 with no dead time; uk=-1 -> duty=1, pwm_b.
- rst low at cnt=37 with pwm_a high -> pwm_a=0 next cycle, duty=0, sample_en resumes 1 cycle after release.
